// File: rtl/decode_stage_v2.sv
// MIPS decode stage: register file, control decode, immediate extension,
// hazard stall counter, in-ID branch/jump resolution and the ID/EX register.
module decode_stage_v2 #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned RA_W            = 5,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned BRANCH_STALLS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_valid_i,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [RA_W-1:0] ex_dst,
  input  logic            flush,
  input  logic            dbg_freeze,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs,
  output logic [RA_W-1:0] ex_rt,
  output logic [RA_W-1:0] ex_wreg,
  output logic [9:0]      ex_ctrl
);

  localparam int unsigned NUM_REGS = 2 ** RA_W;
  localparam int unsigned CNT_W    = 3;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_FUNCT = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SUB   = 3'd5;

  // Register file; r0 is never written so it always reads zero.
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic            wb_en;

  assign wb_en = wb_we & ~dbg_freeze & (wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  logic [5:0]      opcode;
  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] rs_val, rt_val;

  assign opcode   = in_instr[31:26];
  assign rs       = RA_W'(in_instr[25:21]);
  assign rt       = RA_W'(in_instr[20:16]);
  assign rd       = RA_W'(in_instr[15:11]);
  assign rs_val   = (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
  assign rt_val   = (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];
  assign dbg_data = (wb_en && wb_addr == dbg_addr) ? wb_data : rf_q[dbg_addr];

  logic [XLEN-1:0] sext, pc_plus4, br_target, j_target;

  assign sext      = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign pc_plus4  = in_pc + XLEN'(4);
  assign br_target = pc_plus4 + (sext << 2);
  assign j_target  = {pc_plus4[XLEN-1:28], in_instr[25:0], 2'b00};

  logic [9:0]      ctrl;
  logic [XLEN-1:0] imm;
  logic [RA_W-1:0] wreg;
  logic            src_rt, is_br, is_jmp, is_jal;

  // Control decode by opcode.
  always_comb begin
    ctrl   = '0;
    imm    = sext;
    wreg   = rt;
    src_rt = 1'b0;
    is_br  = 1'b0;
    is_jmp = 1'b0;
    is_jal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl[0] = 1'b1; ctrl[8:6] = ALU_FUNCT; wreg = rd; src_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl[0] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl[0] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_AND; imm = XLEN'(in_instr[15:0]);
      end
      OP_ORI: begin
        ctrl[0] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_OR; imm = XLEN'(in_instr[15:0]);
      end
      OP_XORI: begin
        ctrl[0] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_XOR; imm = XLEN'(in_instr[15:0]);
      end
      OP_LUI: begin
        ctrl[0] = 1'b1; ctrl[4] = 1'b1; ctrl[9] = 1'b1; imm = XLEN'({in_instr[15:0], 16'h0000});
      end
      OP_LW: begin
        ctrl[0] = 1'b1; ctrl[1] = 1'b1; ctrl[3] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_ADD;
      end
      OP_SW: begin
        ctrl[2] = 1'b1; ctrl[4] = 1'b1; ctrl[8:6] = ALU_ADD; src_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl[8:6] = ALU_SUB; src_rt = 1'b1; is_br = 1'b1;
      end
      OP_J: is_jmp = 1'b1;
      OP_JAL: begin
        ctrl[0] = 1'b1; ctrl[5] = 1'b1; wreg = '1; is_jmp = 1'b1; is_jal = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazard detection and required bubble count.
  logic             dep, hz, stall, taken, issue;
  logic [CNT_W-1:0] need, cnt_q, cnt_d;

  assign dep   = in_valid & ex_valid_i & (ex_dst != '0) &
                 ((ex_dst == rs) | (src_rt & (ex_dst == rt)));
  assign hz    = dep & (ex_mem_read | (is_br & ex_reg_write));
  assign need  = (is_br && ex_mem_read) ? CNT_W'(LOAD_USE_STALLS + 1) :
                 ex_mem_read            ? CNT_W'(LOAD_USE_STALLS)     :
                                          CNT_W'(BRANCH_STALLS);
  assign stall = hz | (cnt_q != '0);
  assign taken = is_jmp | (opcode == OP_BEQ && rs_val == rt_val) |
                 (opcode == OP_BNE && rs_val != rt_val);
  assign issue = in_valid & ~stall & ~flush;

  assign pc_write    = ~dbg_freeze & (flush | ~stall);
  assign ifid_write  = ~dbg_freeze & (flush | ~stall);
  assign redirect    = ~dbg_freeze & issue & taken;
  assign redirect_pc = is_jmp ? j_target : br_target;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d;
  logic [RA_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_wreg_q, ex_wreg_d;
  logic [9:0]      ex_ctrl_q, ex_ctrl_d;

  // ID/EX and stall-counter next state; freeze holds, otherwise bubble unless issuing.
  always_comb begin
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    ex_wreg_d  = ex_wreg_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (!dbg_freeze) begin
      if (flush)                   cnt_d = '0;
      else if (hz && cnt_q == '0)  cnt_d = need - CNT_W'(1);
      else if (cnt_q != '0)        cnt_d = cnt_q - CNT_W'(1);
      ex_valid_d = issue;
      ex_pc_d    = issue ? in_pc : '0;
      ex_a_d     = !issue ? '0 : is_jal ? (in_pc + XLEN'(8)) : rs_val;
      ex_b_d     = issue ? rt_val : '0;
      ex_imm_d   = issue ? imm : '0;
      ex_rs_d    = issue ? rs : '0;
      ex_rt_d    = issue ? rt : '0;
      ex_wreg_d  = issue ? wreg : '0;
      ex_ctrl_d  = issue ? ctrl : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_wreg_q  <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_pc    = ex_pc_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;
  assign ex_imm   = ex_imm_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign ex_wreg  = ex_wreg_q;
  assign ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2 (LOAD_USE_STALLS=2, BRANCH_STALLS=1).
module tb_decode_stage_v2;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;
  // Control bits with a defined meaning (alu_op excluded).
  localparam logic [9:0] CMASK = 10'h23F;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            wb_we;
  logic [RA_W-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid_i, ex_mem_read, ex_reg_write;
  logic [RA_W-1:0] ex_dst;
  logic            flush, dbg_freeze;
  logic [RA_W-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic            pc_write, ifid_write, redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [RA_W-1:0] ex_rs, ex_rt, ex_wreg;
  logic [9:0]      ex_ctrl;

  int total = 0;
  int bad   = 0;

  decode_stage_v2 #(
    .XLEN(XLEN), .RA_W(RA_W), .LOAD_USE_STALLS(2), .BRANCH_STALLS(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid_i(ex_valid_i), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dst(ex_dst), .flush(flush), .dbg_freeze(dbg_freeze), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .pc_write(pc_write), .ifid_write(ifid_write),
    .redirect(redirect), .redirect_pc(redirect_pc), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input int s, input int t, input int d);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'd32};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int target);
    return {6'(op), 26'(target)};
  endfunction

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    wb_we = 1'b1; wb_addr = RA_W'(a); wb_data = d;
    step();
    wb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_valid_i = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = '0;
    flush = 1'b0; dbg_freeze = 1'b0; dbg_addr = '0;
    step(); step();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd1);
    chk("rst_ifid_write", 64'(ifid_write), 64'd1);
    chk("rst_redirect", 64'(redirect), 64'd0);
    rst = 1'b0;

    wr(1, 32'd5); wr(2, 32'd5); wr(4, 32'd7);
    dbg_addr = 5'd1; #1;
    chk("dbg_r1", 64'(dbg_data), 64'd5);

    // write to r0 is dropped, including the bypass path
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; dbg_addr = 5'd0; #1;
    chk("r0_bypass", 64'(dbg_data), 64'd0);
    step(); wb_we = 1'b0; #1;
    chk("r0_after", 64'(dbg_data), 64'd0);

    // same-cycle writeback bypass into rs: addi r8, r7, -4
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    in_valid = 1'b1; in_pc = 32'h40; in_instr = i_ins(8, 7, 8, -4); dbg_addr = 5'd7; #1;
    chk("dbg_bypass", 64'(dbg_data), 64'hDEADBEEF);
    step(); wb_we = 1'b0;
    chk("byp_ex_a", 64'(ex_a), 64'hDEADBEEF);
    chk("addi_imm", 64'(ex_imm), 64'hFFFFFFFC);
    chk("addi_wreg", 64'(ex_wreg), 64'd8);
    chk("addi_ctrl", 64'(ex_ctrl & CMASK), 64'h011);
    chk("addi_valid", 64'(ex_valid), 64'd1);

    in_instr = i_ins(13, 0, 9, 'h8001); step();
    chk("ori_imm", 64'(ex_imm), 64'h00008001);
    in_instr = i_ins(15, 0, 10, 'h1234); step();
    chk("lui_imm", 64'(ex_imm), 64'h12340000);
    chk("lui_ctrl", 64'(ex_ctrl & CMASK), 64'h211);

    // beq r1,r2,+3 at 0x100 with r1==r2
    in_pc = 32'h100; in_instr = i_ins(4, 1, 2, 3); #1;
    chk("beq_redirect", 64'(redirect), 64'd1);
    chk("beq_target", 64'(redirect_pc), 64'h110);
    step();
    in_instr = i_ins(5, 1, 2, 3); #1;
    chk("bne_redirect", 64'(redirect), 64'd0);
    step();

    // jal with target field 0x0400000 at 0x0040_0000
    in_pc = 32'h0040_0000; in_instr = j_ins(3, 'h0400000); #1;
    chk("jal_redirect", 64'(redirect), 64'd1);
    chk("jal_target", 64'(redirect_pc), 64'h0100_0000);
    step();
    chk("jal_wreg", 64'(ex_wreg), 64'd31);
    chk("jal_link", 64'(ex_a), 64'h0040_0008);
    chk("jal_ctrl", 64'(ex_ctrl & CMASK), 64'h021);

    // load-use: lw r2 in EX, add r3,r2,r4 in ID -> two bubbles
    in_pc = 32'h200; in_instr = r_ins(2, 4, 3);
    ex_valid_i = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2; #1;
    chk("lu_pc_write0", 64'(pc_write), 64'd0);
    chk("lu_ifid_write0", 64'(ifid_write), 64'd0);
    step();
    chk("lu_bubble1", 64'(ex_valid), 64'd0);
    ex_valid_i = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; #1;
    chk("lu_pc_write1", 64'(pc_write), 64'd0);
    step();
    chk("lu_bubble2", 64'(ex_valid), 64'd0);
    #1;
    chk("lu_pc_write2", 64'(pc_write), 64'd1);
    step();
    chk("lu_issue_valid", 64'(ex_valid), 64'd1);
    chk("lu_issue_pc", 64'(ex_pc), 64'h200);
    chk("lu_issue_a", 64'(ex_a), 64'd5);
    chk("lu_issue_b", 64'(ex_b), 64'd7);
    chk("lu_issue_wreg", 64'(ex_wreg), 64'd3);

    // rt of addi is a destination, not a source: no hazard
    in_instr = i_ins(8, 6, 2, 1);
    ex_valid_i = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2; #1;
    chk("nohz_addi_rt", 64'(pc_write), 64'd1);
    // ALU result feeding a non-branch: forwarded, no stall
    ex_mem_read = 1'b0; ex_dst = 5'd1; in_instr = r_ins(1, 2, 3); #1;
    chk("nohz_alu", 64'(pc_write), 64'd1);
    step();

    // branch on EX ALU result: one bubble
    in_pc = 32'h100; in_instr = i_ins(4, 1, 2, 3); #1;
    chk("bralu_stall", 64'(pc_write), 64'd0);
    chk("bralu_noredir", 64'(redirect), 64'd0);
    step();
    chk("bralu_bubble", 64'(ex_valid), 64'd0);
    ex_valid_i = 1'b0; ex_reg_write = 1'b0; #1;
    chk("bralu_redirect", 64'(redirect), 64'd1);
    step();

    // branch on load: three bubbles, cut short by flush
    ex_valid_i = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd2; #1;
    chk("brld_stall0", 64'(pc_write), 64'd0);
    step();
    ex_valid_i = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; #1;
    chk("brld_stall1", 64'(pc_write), 64'd0);
    flush = 1'b1; #1;
    chk("flush_pc_write", 64'(pc_write), 64'd1);
    chk("flush_noredir", 64'(redirect), 64'd0);
    step(); flush = 1'b0;
    chk("flush_bubble", 64'(ex_valid), 64'd0);
    #1;
    chk("flush_cnt0", 64'(pc_write), 64'd1);
    chk("flush_redirect", 64'(redirect), 64'd1);
    step();

    // debug freeze holds ID/EX and blocks writeback
    in_pc = 32'h300; in_instr = i_ins(8, 1, 9, 1); step();
    chk("pre_frz_pc", 64'(ex_pc), 64'h300);
    dbg_freeze = 1'b1; wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'hAAAA;
    in_pc = 32'h304; in_instr = j_ins(2, 0); dbg_addr = 5'd1; #1;
    chk("frz_dbg", 64'(dbg_data), 64'd5);
    chk("frz_pc_write", 64'(pc_write), 64'd0);
    chk("frz_redirect", 64'(redirect), 64'd0);
    step();
    chk("frz_hold_pc", 64'(ex_pc), 64'h300);
    chk("frz_hold_valid", 64'(ex_valid), 64'd1);
    dbg_freeze = 1'b0; wb_we = 1'b0; in_valid = 1'b0; #1;
    chk("frz_no_write", 64'(dbg_data), 64'd5);

    // asynchronous reset while the counter is at 2
    in_valid = 1'b1; in_pc = 32'h100; in_instr = i_ins(4, 1, 2, 3);
    ex_valid_i = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd2;
    step();
    ex_valid_i = 1'b0; ex_mem_read = 1'b0; #1;
    chk("pre_rst_stall", 64'(pc_write), 64'd0);
    #2; rst = 1'b1; #1;
    chk("mrst_ex_valid", 64'(ex_valid), 64'd0);
    chk("mrst_cnt0", 64'(pc_write), 64'd1);
    chk("mrst_r1", 64'(dbg_data), 64'd0);
    step(); rst = 1'b0; in_valid = 1'b0;
    step();
    dbg_addr = 5'd2; #1;
    chk("post_rst_r2", 64'(dbg_data), 64'd0);
    dbg_addr = 5'd7; #1;
    chk("post_rst_r7", 64'(dbg_data), 64'd0);
    chk("post_rst_ctrl", 64'(ex_ctrl), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
